// File: rtl/decoder_arbiter_if.sv
// Arbiter bus between the requesters and the shared-decoder arbiter.
//   req           : request lines, bit n = requester n wants the decoder
//   release_grant : current owner gives up its grant
//   sel           : binary index of the granted requester (decoder i0..i3)
//   busy          : grant active; the decoder output is qualified by it
//   grant_start   : one-cycle pulse on the first cycle of every grant
// The release line cannot be called "release" because that word is reserved
// in SystemVerilog.
interface decoder_arbiter_if;
  logic [15:0] req;
  logic        release_grant;
  logic [3:0]  sel;
  logic        busy;
  logic        grant_start;

  // Requester side.
  modport master (
    output req, release_grant,
    input  sel, busy, grant_start
  );

  // Arbiter side.
  modport slave (
    input  req, release_grant,
    output sel, busy, grant_start
  );
endinterface

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter that grants one of 16 requesters ownership of a shared
// 4-to-16 decoder. A grant lasts until the owner releases it, drops its
// request, or has held it for MAX_HOLD cycles. At least one IDLE cycle
// separates consecutive grants, and arbitration happens in that cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : decoder_arbiter_if.slave (req, release_grant in; sel, busy,
//           grant_start out)
module decoder_arbiter #(
  parameter int MAX_HOLD = 8      // legal range 1..255
) (
  input  logic              clk,
  input  logic              reset,
  decoder_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_sel;
  logic [3:0] r_last;
  logic       r_busy;
  logic       r_grant_start;
  logic [7:0] r_hold;

  logic [15:0] w_rot;
  logic [3:0]  w_offset;
  logic [3:0]  w_pick;
  logic        w_any;
  logic        w_exit;

  // Rotate the request vector so that bit 0 is requester (last+1) mod 16.
  // The previous owner lands on bit 15, so it is reached last.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      assign w_rot[gi] = bus.req[r_last + 4'(gi + 1)];
    end
  endgenerate

  // The lowest set bit of the rotated vector is the winner's distance from
  // last+1.
  always_comb begin
    w_offset = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (w_rot[k]) w_offset = 4'(k);
    end
  end

  assign w_any  = |bus.req;
  assign w_pick = r_last + 4'd1 + w_offset;

  // Several exit causes can be true at once; they all collapse into one exit.
  assign w_exit = bus.release_grant | ~bus.req[r_sel] | (r_hold == 8'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sel         <= 4'd0;
      r_last        <= 4'd15;
      r_busy        <= 1'b0;
      r_grant_start <= 1'b0;
      r_hold        <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_grant_start <= 1'b0;
          if (w_any) begin
            r_sel         <= w_pick;
            r_last        <= w_pick;
            r_state       <= GRANT;
            r_busy        <= 1'b1;
            r_grant_start <= 1'b1;
            r_hold        <= 8'd1;
          end
        end
        GRANT: begin
          r_grant_start <= 1'b0;
          if (w_exit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_hold  <= 8'd0;
          end else begin
            // Never wraps: the exit at MAX_HOLD (<= 255) stops it first.
            r_hold <= r_hold + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel         = r_sel;
  assign bus.busy        = r_busy;
  assign bus.grant_start = r_grant_start;

endmodule

// File: tb/tb_decoder_arbiter.sv
module tb_decoder_arbiter;

  logic clk = 1'b0;
  logic reset;

  decoder_arbiter_if bus ();

  decoder_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_q[$];          // expected sel of each upcoming grant, in order
  logic [3:0] prev_sel;

  task automatic check_val(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 16'h0000;
    bus.release_grant = 1'b0;
    tick();
    tick();
    check_val("rst_sel", bus.sel, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_gs", bus.grant_start, 0);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: each grant_start pops the expected sel.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (bus.grant_start) begin
        $display("grant sel=%0d t=%0t", bus.sel, $time);
        check_val("gs_with_busy", bus.busy, 1);
        if (exp_q.size() == 0) check_val("unexpected_grant", 1, 0);
        else check_val("grant_sel", bus.sel, exp_q.pop_front());
      end else if (bus.busy) begin
        check_val("sel_stable", bus.sel, prev_sel);
      end
    end
    prev_sel = bus.sel;
  end

  initial begin
    int cnt;
    reset = 1'b1;
    bus.req = 16'h0000;
    bus.release_grant = 1'b0;

    // Single request from reset: latency one clock, one-cycle pulse.
    do_reset();
    exp_q.push_back(0);
    bus.req = 16'h0001;
    tick();
    check_val("s25_busy", bus.busy, 1);
    check_val("s25_gs", bus.grant_start, 1);
    check_val("s25_sel", bus.sel, 0);
    tick();
    check_val("s25_gs_low", bus.grant_start, 0);
    check_val("s25_busy_hold", bus.busy, 1);
    bus.req = 16'h0000;
    tick();
    check_val("s25_drop", bus.busy, 0);
    tick();

    // All requesting, release on each grant's second cycle: 0..15 then 0.
    do_reset();
    for (int g = 0; g < 16; g++) exp_q.push_back(g);
    exp_q.push_back(0);
    bus.req = 16'hFFFF;
    tick();
    for (int g = 0; g < 17; g++) begin
      check_val("s26_start", bus.grant_start, 1);
      tick();
      bus.release_grant = 1'b1;
      tick();
      bus.release_grant = 1'b0;
      check_val("s26_idle", bus.busy, 0);
      if (g == 16) bus.req = 16'h0000;
      tick();
    end
    check_val("s26_end_idle", bus.busy, 0);

    // Held request with no release: exactly MAX_HOLD busy cycles, re-grant.
    do_reset();
    exp_q.push_back(4);
    exp_q.push_back(4);
    bus.req = 16'h0010;
    tick();
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check_val("s27_hold_len", cnt, 8);
    tick();
    check_val("s27_regrant", bus.grant_start, 1);
    bus.req = 16'h0000;
    tick();
    tick();

    // Wrap past 15: last = 14, req 0x4001 -> 0 then 14.
    do_reset();
    exp_q.push_back(14);
    bus.req = 16'h4000;
    tick();
    check_val("s28_first", bus.grant_start, 1);
    bus.req = 16'h0000;
    tick();
    exp_q.push_back(0);
    exp_q.push_back(14);
    bus.req = 16'h4001;
    tick();
    check_val("s28_wrap_gs", bus.grant_start, 1);
    bus.release_grant = 1'b1;
    tick();
    bus.release_grant = 1'b0;
    check_val("s28_rel", bus.busy, 0);
    tick();
    check_val("s28_second_gs", bus.grant_start, 1);
    // Release and request drop on the same edge: one clean exit.
    bus.release_grant = 1'b1;
    bus.req = 16'h0000;
    tick();
    bus.release_grant = 1'b0;
    check_val("s28_dual_exit", bus.busy, 0);
    tick();
    check_val("s28_no_regrant", bus.busy, 0);

    // Owner drops while another rises; other bits don't disturb the grant.
    do_reset();
    exp_q.push_back(3);
    exp_q.push_back(7);
    bus.req = 16'h0008;
    tick();
    bus.req = 16'h0108;
    tick();
    check_val("s29_other_busy", bus.busy, 1);
    check_val("s29_other_sel", bus.sel, 3);
    bus.req = 16'h0080;
    tick();
    check_val("s29_drop", bus.busy, 0);
    tick();
    check_val("s29_next_gs", bus.grant_start, 1);
    check_val("s29_next_sel", bus.sel, 7);
    bus.req = 16'h0000;
    tick();
    tick();

    // Reset mid-grant wins over requests; priority restarts at 0.
    do_reset();
    exp_q.push_back(9);
    bus.req = 16'h0200;
    tick();
    tick();
    reset = 1'b1;
    bus.req = 16'h0201;
    tick();
    check_val("s30_busy", bus.busy, 0);
    check_val("s30_sel", bus.sel, 0);
    check_val("s30_gs", bus.grant_start, 0);
    reset = 1'b0;
    exp_q.push_back(0);
    tick();
    check_val("s30_gs_after", bus.grant_start, 1);
    check_val("s30_sel_after", bus.sel, 0);
    bus.req = 16'h0000;
    tick();
    tick();

    check_val("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/decoder_arbiter.md
DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high, ports named clk and reset.
REQ-002 Parameter MAX_HOLD, default 8, meaning the maximum number of cycles one requester may hold the grant (legal range 1..255).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port req  input  16  request lines; bit n = requester n wants the shared decoder output.
REQ-006 Port release  input  1  asserted by the current owner to give up the grant.
REQ-007 Port sel  output  4  binary index of the granted requester; sel[0..3] drive decoder inputs i0..i3.
REQ-008 Port busy  output  1  high while a grant is active; the decoder output is qualified by busy.
REQ-009 Port grant_start  output  1  single-cycle pulse on the first cycle of each new grant.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 IDLE with req == 0: remain IDLE; sel holds its previous value; busy = 0.
REQ-012 IDLE with req != 0: select the first set bit scanning upward from (last+1) mod 16 with wrap 15->0; register its index into sel and last; enter GRANT; busy = 1 and grant_start = 1 on the next cycle (latency 1 clock from request to grant).
REQ-013 GRANT: the hold counter SHALL load 1 on entry and increment each cycle the grant is retained.
REQ-014 GRANT SHALL exit to IDLE when any of these holds: release = 1, req[sel] = 0, or the hold counter = MAX_HOLD.
REQ-015 On exit, busy SHALL drop on the next cycle; at least one IDLE cycle SHALL separate consecutive grants, and arbitration happens in that IDLE cycle.
REQ-016 Simultaneous exit conditions SHALL cause a single exit with no priority distinction and no error.
REQ-017 Requests arriving or dropping on bits other than sel during GRANT SHALL NOT affect the current grant.
REQ-018 The sole requester SHALL be re-granted after its IDLE bubble, because the wrap-around scan reaches it last.
REQ-019 sel SHALL change only on the IDLE->GRANT transition; it SHALL be stable for the whole grant.
REQ-020 grant_start SHALL be high for exactly one cycle per grant and never while busy is low.
REQ-021 The hold counter SHALL be 8 bits wide and SHALL never wrap; it saturates at MAX_HOLD via the exit rule.

Reset
REQ-022 reset SHALL force state IDLE, sel = 0, busy = 0, grant_start = 0, hold counter = 0, last = 15 (requester 0 highest priority after reset).
REQ-023 reset asserted during GRANT SHALL terminate the grant at that edge, with busy = 0 on the following cycle regardless of req or release.
REQ-024 reset SHALL take precedence over every other input on the same edge.

Verification
REQ-025 After reset, req = 0x0001 at cycle 0 -> cycle 1: sel = 0, busy = 1, grant_start = 1; cycle 2: grant_start = 0.
REQ-026 After reset, req = 0xFFFF held with release pulsed on each grant's 2nd cycle -> grant order sel = 0,1,2,...,15,0, with one IDLE cycle between grants.
REQ-027 MAX_HOLD = 8, req = 0x0010 held, release = 0 -> busy high for exactly 8 cycles with sel = 4, then 1 IDLE cycle, then re-grant to sel = 4.
REQ-028 last = 14, req = 0x4001 -> next grant sel = 0 (wrap past 15); the following grant sel = 14.
REQ-029 Grant active on sel = 3 and req[3] drops while req[7] rises -> busy low next cycle, then grant to sel = 7.
REQ-030 reset asserted mid-grant on sel = 9 -> next cycle busy = 0, sel = 0; after deassert, req = 0x0201 -> grant sel = 0.
